// File: rtl/e_mdu_if.sv
// e_mdu_if: issue/result bundle between the E stage and the multiply/divide unit
interface e_mdu_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [3:0]       MDUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Req;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, MDUOp, A, B, Req, input Busy, Done, HI, LO);
    modport slave  (input Start, MDUOp, A, B, Req, output Busy, Done, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning HI/LO, with Busy/Done handshake
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset_n,
    e_mdu_if.slave mdu
);
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, stateNext;
    logic [CW-1:0]      cnt, cntNext;
    logic [WIDTH-1:0]   hi, lo, ph, pl, hiNext, loNext, phNext, plNext;
    logic               done, doneNext;
    logic [3:0]         op;
    logic               accept, isArith, isDiv, isSigned, isMac, isSub, divZero;
    logic [2*WIDTH-1:0] aExt, bExt, prod, acc, macRes, divRes;
    logic [WIDTH-1:0]   absA, absB, divisor, uq, ur, q, r;

    assign op       = mdu.MDUOp;
    assign isArith  = op >= 4'd1 && op <= 4'd8;
    assign isDiv    = op == 4'd3 || op == 4'd4;
    assign isSigned = op == 4'd1 || op == 4'd3 || op == 4'd5 || op == 4'd7;
    assign isMac    = op >= 4'd5 && op <= 4'd8;
    assign isSub    = op == 4'd7 || op == 4'd8;
    assign accept   = mdu.Start & ~mdu.Req & (state == IDLE);

    // Sign- or zero-extend so one 2W-bit multiply serves both signednesses.
    assign aExt   = isSigned ? {{WIDTH{mdu.A[WIDTH-1]}}, mdu.A} : {{WIDTH{1'b0}}, mdu.A};
    assign bExt   = isSigned ? {{WIDTH{mdu.B[WIDTH-1]}}, mdu.B} : {{WIDTH{1'b0}}, mdu.B};
    assign prod   = aExt * bExt;
    assign acc    = {hi, lo};
    assign macRes = ~isMac ? prod : isSub ? acc - prod : acc + prod;

    // Signed divide on magnitudes; most-negative / -1 wraps back to most-negative naturally.
    assign divZero = mdu.B == '0;
    assign absA    = isSigned & mdu.A[WIDTH-1] ? -mdu.A : mdu.A;
    assign absB    = isSigned & mdu.B[WIDTH-1] ? -mdu.B : mdu.B;
    assign divisor = divZero ? WIDTH'(1) : absB;
    assign uq      = absA / divisor;
    assign ur      = absA % divisor;
    assign q       = isSigned & (mdu.A[WIDTH-1] ^ mdu.B[WIDTH-1]) ? -uq : uq;
    assign r       = isSigned & mdu.A[WIDTH-1] ? -ur : ur;
    assign divRes  = divZero ? acc : {r, q};

    assign mdu.Busy = state == RUN;
    assign mdu.Done = done;
    assign mdu.HI   = hi;
    assign mdu.LO   = lo;

    // Next-state: issue latches the pending result, RUN counts down and commits at 1->0.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        hiNext    = hi;
        loNext    = lo;
        phNext    = ph;
        plNext    = pl;
        doneNext  = 1'b0;
        if (state == RUN) begin
            cntNext = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                stateNext = IDLE;
                hiNext    = ph;
                loNext    = pl;
                doneNext  = 1'b1;
            end
        end else if (accept) begin
            if (isArith) begin
                {phNext, plNext} = isDiv ? divRes : macRes;
                cntNext          = isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                stateNext        = RUN;
            end else if (op == 4'd9) begin
                hiNext = mdu.A;
            end else if (op == 4'd10) begin
                loNext = mdu.A;
            end
        end
    end

    // State and HI/LO registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            ph    <= '0;
            pl    <= '0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            hi    <= hiNext;
            lo    <= loNext;
            ph    <= phNext;
            pl    <= plNext;
            done  <= doneNext;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors with a Done-driven scoreboard for e_mdu
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    e_mdu_if #(.WIDTH(32)) m();

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mdu(m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; the op is accepted at the following posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
        m.Start = 1'b1;
        m.MDUOp = op;
        m.A     = a;
        m.B     = b;
        m.Req   = req;
        @(posedge clk);
        #1;
        m.Start = 1'b0;
        m.Req   = 1'b0;
        m.MDUOp = 4'd0;
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int n);
        logic [63:0] pre;
        int cnt;
        bit held;
        pre = {m.HI, m.LO};
        sb.push_back(exp);
        issue(op, a, b, 1'b0);
        cnt  = 0;
        held = 1'b1;
        @(negedge clk);
        while (m.Busy === 1'b1 && cnt < 50) begin
            cnt++;
            if ({m.HI, m.LO} !== pre) held = 1'b0;
            @(negedge clk);
        end
        check({name, " busyCycles"}, 64'(cnt), 64'(n));
        check({name, " holdWhileBusy"}, 64'(held), 64'd1);
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        issue(op, a, 32'd0, 1'b0);
        @(negedge clk);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (m.Done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpectedDone", 64'd1, 64'd0);
                end else begin
                    check("commitHiLo", {m.HI, m.LO}, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m.Start = 1'b0;
        m.MDUOp = 4'd0;
        m.A     = '0;
        m.B     = '0;
        m.Req   = 1'b0;
        repeat (3) @(negedge clk);
        check("resetBusy", 64'(m.Busy), 64'd0);
        check("resetDone", 64'(m.Done), 64'd0);
        check("resetHiLo", {m.HI, m.LO}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        runOp("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5);
        runOp("divNeg", 4'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
        runOp("divOvf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);
        runOp("divu", 4'd4, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10);

        @(negedge clk);
        move(4'd9, 32'd5);
        check("mthi", 64'(m.HI), 64'd5);
        move(4'd10, 32'd6);
        check("mtloBusy", 64'(m.Busy), 64'd0);
        runOp("divuZero", 4'd4, 32'd77, 32'd0, 64'h0000_0005_0000_0006, 10);

        @(negedge clk);
        move(4'd9, 32'd0);
        move(4'd10, 32'hFFFF_FFFF);
        runOp("maddu", 4'd6, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5);
        runOp("msub", 4'd7, 32'd1, 32'd2, 64'h0000_0000_FFFF_FFFE, 5);

        @(negedge clk);
        issue(4'd1, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        check("reqBusy", 64'(m.Busy), 64'd0);
        @(negedge clk);
        check("reqHiLo", {m.HI, m.LO}, 64'h0000_0000_FFFF_FFFE);

        sb.push_back(64'd6);
        issue(4'd1, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        issue(4'd10, 32'h1234, 32'd0, 1'b0);
        for (int i = 0; i < 20 && m.Busy === 1'b1; i++) @(negedge clk);
        check("mtloWhileBusy", 64'(m.LO), 64'd6);

        @(negedge clk);
        move(4'd10, 32'h1234);
        check("mtloIdle", 64'(m.LO), 64'h1234);
        check("mtloIdleBusy", 64'(m.Busy), 64'd0);

        issue(4'd1, 32'd7, 32'd9, 1'b0);
        repeat (3) @(negedge clk);
        check("preResetBusy", 64'(m.Busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("asyncResetHiLo", {m.HI, m.LO}, 64'd0);
        check("asyncResetBusy", 64'(m.Busy), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("noDoneAfterReset", 64'(m.Done), 64'd0);
        check("idleAfterReset", {m.HI, m.LO}, 64'd0);

        runOp("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
        repeat (3) @(negedge clk);
        check("scoreboardDrained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multi-cycle multiply/divide unit for the E stage, working alongside the E-stage ALU. It executes mult/multu/div/divu and the accumulating madd/maddu/msub/msubu forms, and owns the HI/LO registers. Arithmetic latency is configurable and reported through a Busy/Done handshake that the hazard unit uses to stall. An exception/interrupt request in the same cycle cancels an issue.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MULT_CYCLES, 5: busy cycles for multiply-class ops (≥1).
- DIV_CYCLES, 10: busy cycles for divide-class ops (≥1).

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  issue strobe, sampled at the rising edge.
- MDUOp  in  4  operation select:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 madd, 6 maddu, 7 msub, 8 msubu
  - 9 mthi, 10 mtlo
  - 11–15 none
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- Req  in  1  exception/interrupt request; suppresses an issue in the same cycle.
- Busy  out  1  registered; high while an op is in flight.
- Done  out  1  registered one-cycle pulse on HI/LO commit.
- HI  out  WIDTH  HI register (mfhi source).
- LO  out  WIDTH  LO register (mflo source).

## Operation
- States: IDLE, RUN. Down-counter of width clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Accept condition: Start & ~Req & ~Busy.
  - Start while Busy is ignored.
  - Start with Req=1 is ignored; no state change.
- On accept of an arithmetic op (1–8):
  - Compute the result combinationally from A, B and the current HI/LO.
  - Latch the result into pending registers PH/PL.
  - Load the counter with the op's latency and go to RUN.
- Multiply-class results:
  - mult: signed 2·WIDTH product. multu: unsigned product.
  - madd(u): {HI,LO} + product. msub(u): {HI,LO} − product. Both modulo 2^(2·WIDTH); signedness follows the op.
- Divide-class results:
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative / −1 gives LO = most-negative, HI = 0.
  - Divide by zero: the op still runs its full latency, then commits with HI/LO unchanged.
- mthi/mtlo on accept: HI (or LO) ← A at that edge. No RUN state, no Busy, no Done.
- RUN: counter decrements each cycle. On the edge where the counter goes 1→0:
  - {HI,LO} ← {PH,PL}
  - Done ← 1 for one cycle
  - Busy ← 0, state → IDLE
- Req during RUN does not abort. A committed op completes (P7 precise-exception model: the op issued before the victim instruction).
- Reset asserted at any time, including mid-RUN:
  - HI = LO = 0, Busy = 0, Done = 0, counter = 0, state IDLE.
  - The in-flight op is discarded.

## Timing
- Accept edge at cycle t:
  - Busy is high in cycles t+1 … t+N, where N is the op's latency.
  - Commit happens at the edge ending cycle t+N.
  - New HI/LO, Done=1 and Busy=0 are all visible in cycle t+N+1.
- Back-to-back issue: a new Start is accepted in cycle t+N+1, the same cycle Done is high.
- mthi/mtlo accepted at edge t: new value visible in cycle t+1.
- HI/LO never change while Busy=1. During RUN they hold the pre-op values.
- Hazard unit must stall mfhi/mflo/mthi/mtlo/MDU ops when (Start & op∈1–8) | Busy. This block does not produce that stall itself.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then mult A=0xFFFF_FFFE, B=3, MULT_CYCLES=5:
  - Busy high 5 cycles.
  - Next cycle: HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, Done=1 for exactly one cycle.
- div A=0xFFFF_FFF9 (−7), B=2:
  - LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1), after 10 busy cycles.
- Overflow and divide-by-zero cases:
  - div 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
  - divu by 0 with HI=5, LO=6 preset → after 10 cycles HI=5, LO=6, Done=1.
- Accumulate chain from HI=0, LO=0xFFFF_FFFF:
  - maddu A=1, B=1 → HI=1, LO=0.
  - Then msub A=1, B=2 → HI=0, LO=0xFFFF_FFFE.
- Suppressed issues:
  - Start with Req=1 → Busy stays 0, HI/LO unchanged.
  - mtlo 0x1234 issued while Busy → ignored.
  - mtlo 0x1234 in idle → LO=0x1234 next cycle, Busy stays 0.
- Reset and re-issue:
  - reset_n pulled low in the 3rd busy cycle of a mult → HI=LO=0 and Busy=0 immediately, no Done.
  - After release, a fresh multu 0xFFFF_FFFF×0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=1.
